cam_array: RTL

//  Parametrised multi-entry content-addressable memory: DEPTH entries of WIDTH bits, each with a valid bit.

---
 rtl/cam_array.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cam_array.sv
// Parametrised content-addressable memory: DEPTH x WIDTH entries with valid bits, indexed read/write,
// registered priority-encoded search and occupancy tracking. Define CAM_MASK_EN for per-bit search masking.
module cam_array #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             write_enable_i,
    input  logic [IDX_W-1:0] write_index_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             invalidate_i,
    input  logic             flush_i,
    input  logic             read_enable_i,
    input  logic [IDX_W-1:0] read_index_i,
    output logic [WIDTH-1:0] read_data_o,
    output logic             read_valid_o,
    input  logic             search_enable_i,
    input  logic [WIDTH-1:0] search_i,
`ifdef CAM_MASK_EN
    input  logic [WIDTH-1:0] search_mask_i,
`endif
    output logic             search_done_o,
    output logic [DEPTH-1:0] match_o,
    output logic             hit_o,
    output logic [IDX_W-1:0] hit_index_o,
    output logic             multi_hit_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic [IDX_W-1:0] free_index_o
);

    logic [WIDTH-1:0] entry [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [DEPTH-1:0] match_p0;
    logic [WIDTH-1:0] rd_data_p0;
    logic             rd_valid_p0;

    logic [WIDTH-1:0] rd_data_p1;
    logic             rd_valid_p1;
    logic             vld_p1;
    logic [DEPTH-1:0] match_p1;
    logic             hit_p1;
    logic [IDX_W-1:0] hit_index_p1;
    logic             multi_hit_p1;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [DEPTH-1:0] v);
        lowest_set = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        popcount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            popcount = popcount + CNT_W'(v[i]);
        end
    endfunction

    function automatic logic more_than_one(input logic [DEPTH-1:0] v);
        more_than_one = (v & (v - DEPTH'(1))) != '0;
    endfunction

    // Stage p0: compare every entry against the key and select the read entry
    always_comb begin
        match_p0 = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef CAM_MASK_EN
            match_p0[i] = valid[i] && (((entry[i] ^ search_i) & search_mask_i) == '0);
`else
            match_p0[i] = valid[i] && (entry[i] == search_i);
`endif
        end
    end

    always_comb begin
        rd_data_p0  = '0;
        rd_valid_p0 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (IDX_W'(i) == read_index_i) begin
                rd_data_p0  = entry[i];
                rd_valid_p0 = valid[i];
            end
        end
    end

    // Storage update; flush overrides write, write overrides invalidate
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
        end else if (flush_i) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IDX_W'(i) == write_index_i) begin
                    if (write_enable_i) begin
                        entry[i] <= data_i;
                        valid[i] <= 1'b1;
                    end else if (invalidate_i) begin
                        valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Stage p1: registered read and search results, all from pre-edge contents
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            rd_data_p1   <= '0;
            rd_valid_p1  <= 1'b0;
            vld_p1       <= 1'b0;
            match_p1     <= '0;
            hit_p1       <= 1'b0;
            hit_index_p1 <= '0;
            multi_hit_p1 <= 1'b0;
        end else begin
            if (read_enable_i) begin
                rd_data_p1  <= rd_data_p0;
                rd_valid_p1 <= rd_valid_p0;
            end
            vld_p1 <= search_enable_i;
            if (search_enable_i) begin
                match_p1     <= match_p0;
                hit_p1       <= |match_p0;
                hit_index_p1 <= lowest_set(match_p0);
                multi_hit_p1 <= more_than_one(match_p0);
            end else begin
                match_p1     <= '0;
                hit_p1       <= 1'b0;
                hit_index_p1 <= '0;
                multi_hit_p1 <= 1'b0;
            end
        end
    end

    assign read_data_o   = rd_data_p1;
    assign read_valid_o  = rd_valid_p1;
    assign search_done_o = vld_p1;
    assign match_o       = match_p1;
    assign hit_o         = hit_p1;
    assign hit_index_o   = hit_index_p1;
    assign multi_hit_o   = multi_hit_p1;

    // Occupancy follows the registered valid bits; lowest_set of ~valid yields 0 when full
    assign count_o      = popcount(valid);
    assign full_o       = (count_o == CNT_W'(DEPTH));
    assign free_index_o = lowest_set(~valid);

endmodule
